// File: rtl/aes_key_schedule_ctrl_if.sv
// aes_key_schedule_ctrl_if
//   Bundles every non-clock/reset signal of the round-key sequencer/store.
//   slave  : the sequencer itself (aes_key_schedule_ctrl).
//   master : whatever surrounds it. That is the cipher datapath for start/key_in/rd_*,
//            and the key expander for kx_out_key.
// Signals:
//   start       request a new expansion (ignored while busy)
//   key_in      128-bit cipher key, captured on the accepted start edge
//   kx_key      latched key presented to the expander
//   kx_count    round index presented to the expander (0..9 during expansion)
//   kx_out_key  round key kx_count+1 returned by the expander (combinational)
//   busy        expansion in progress
//   keys_ready  all 11 round keys valid in the store
//   rd_addr     round-key index to read (0..10; 11..15 read as zero)
//   rd_data     registered read data, one cycle after rd_addr
interface aes_key_schedule_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] kx_key;
  logic [3:0]   kx_count;
  logic [127:0] kx_out_key;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  modport master (
    output start, key_in, kx_out_key, rd_addr,
    input  kx_key, kx_count, busy, keys_ready, rd_data
  );

  modport slave (
    input  start, key_in, kx_out_key, rd_addr,
    output kx_key, kx_count, busy, keys_ready, rd_data
  );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl
//   Sequences an external AES-128 key expander through rounds 0..9, one round per clock.
//   Captures every round key into an 11-entry store.
//   Serves the stored keys through a registered read port.
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset; clears FSM, key register, store and read data
//   bus    aes_key_schedule_ctrl_if.slave (see interface header for signal list)
// Parameters:
//   NR     number of rounds; the store holds NR+1 keys. Only 10 (AES-128) is meaningful.
module aes_key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_key_schedule_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'(NR - 1);
  localparam logic [3:0] MAX_ADDR  = 4'(NR);

  state_t       state_reg, state_next;
  logic [3:0]   count_reg, count_next;
  logic [127:0] key_reg, key_next;
  logic         accept;

  logic [NR:0]  slot_we;
  logic [127:0] slot_reg [0:NR];
  logic [127:0] rd_data_reg;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      key_reg   <= key_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. A start request is only looked at outside EXPAND, so a request
  // arriving on the final expansion step is dropped rather than queued.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    key_next   = key_reg;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          key_next   = bus.key_in;
          count_next = '0;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        // The expander chains round c into round c+1 internally, so the count
        // must advance by exactly one per cycle with no holds.
        if (count_reg == LAST_STEP) begin
          count_next = '0;
          state_next = DONE;
        end else begin
          count_next = count_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store write enables. Slot 0 is the cipher key itself, taken on the accept edge.
  // Slot gi (gi>=1) is the expander output during the step where kx_count = gi-1.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_slot_we
      if (gi == 0) begin : g_key
        assign slot_we[gi] = accept;
      end else begin : g_round
        assign slot_we[gi] = (state_reg == EXPAND) && (count_reg == 4'(gi - 1));
      end
    end
  endgenerate

  // Storage is reset so that keys from an aborted expansion never leak out
  // after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (slot_we[i]) begin
          slot_reg[i] <= (i == 0) ? bus.key_in : bus.kx_out_key;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port. The read samples slot_reg before this edge's write,
  // so read-during-write returns the old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (bus.rd_addr <= MAX_ADDR) begin
      rd_data_reg <= slot_reg[bus.rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: busy/keys_ready decode straight from the state register.
  // kx_count is already forced to 0 outside EXPAND by the next-state logic.
  // ---------------------------------------------------------------------------
  assign bus.kx_key     = key_reg;
  assign bus.kx_count   = count_reg;
  assign bus.busy       = (state_reg == EXPAND);
  assign bus.keys_ready = (state_reg == DONE);
  assign bus.rd_data    = rd_data_reg;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl
//   Self-checking bench for aes_key_schedule_ctrl.
//   The key expander is stood in for by a behavioural AES-128 key schedule.
//   The expected behaviour comes from a model that tracks:
//     - the age of the current expansion (edges since the accepted start),
//     - the current key,
//     - the key of the previous complete key set.
//   Expected store contents are derived from those three quantities.
module tb_aes_key_schedule_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  aes_key_schedule_ctrl_if ifc();

  aes_key_schedule_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  bit cmp_en   = 1'b0;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // AES-128 key schedule, straight from the algorithm definition
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, b;
    int e;
    r = 8'h01; b = x; e = 254;       // x^254 is the field inverse (0 maps to 0)
    while (e != 0) begin
      if (e[0]) r = gmul(r, b);
      b = gmul(b, b);
      e = e >> 1;
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    w0 = key[127:96]; w1 = key[95:64]; w2 = key[63:32]; w3 = key[31:0];
    rcon = 8'h01;
    for (int j = 1; j <= r; j++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rcon = xtime(rcon);
    end
    return {w0, w1, w2, w3};
  endfunction

  // Expander stand-in: returns round key kx_count+1 of the presented key.
  always_comb ifc.kx_out_key = round_key(ifc.kx_key, int'(ifc.kx_count) + 1);

  // ---------------------------------------------------------------------------
  // Reference model
  //   m_age       : -1 = no expansion since reset; otherwise edges since accept, capped at 10.
  //   m_cur       : key of the expansion in flight or just finished.
  //   m_prev      : key of the last complete key set, valid when m_prev_valid.
  //   Slots 0..m_age already hold m_cur's keys; the rest hold m_prev's (or zero).
  // ---------------------------------------------------------------------------
  int           m_age;
  logic [127:0] m_cur, m_prev, m_rd;
  bit           m_prev_valid;

  function automatic logic [127:0] exp_slot(input int k);
    if (m_age >= 0 && k <= m_age) return round_key(m_cur, k);
    if (m_prev_valid) return round_key(m_prev, k);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age        <= -1;
      m_cur        <= '0;
      m_prev       <= '0;
      m_prev_valid <= 1'b0;
      m_rd         <= '0;
    end else begin
      m_rd <= (ifc.rd_addr <= 4'd10) ? exp_slot(int'(ifc.rd_addr)) : '0;
      if (ifc.start && !(m_age >= 0 && m_age < 10)) begin
        if (m_age == 10) begin
          m_prev       <= m_cur;
          m_prev_valid <= 1'b1;
        end
        m_cur <= ifc.key_in;
        m_age <= 0;
      end else if (m_age >= 0 && m_age < 10) begin
        m_age <= m_age + 1;
      end
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_int("busy", int'(ifc.busy), int'(m_age >= 0 && m_age < 10));
      check_int("keys_ready", int'(ifc.keys_ready), int'(m_age == 10));
      check_int("kx_count", int'(ifc.kx_count), (m_age >= 0 && m_age < 10) ? m_age : 0);
      check_vec("kx_key", ifc.kx_key, m_cur);
      check_vec("rd_data", ifc.rd_data, m_rd);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic read_slot(input logic [3:0] a, output logic [127:0] d);
    @(negedge clk);
    ifc.rd_addr = a;
    @(negedge clk);
    d = ifc.rd_data;
  endtask

  // mode 0: plain; mode 1: stray start pulses at T3, T9, T10; mode 2: rst_n drop at T5.
  task automatic expand(input logic [127:0] k, input int mode);
    int e, busy_cycles;
    bit seq_ok;
    logic [127:0] d;
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.key_in = k;
    @(negedge clk);
    ifc.start = 1'b0;
    check_int("accept_ready_low", int'(ifc.keys_ready), 0);
    e = 0; busy_cycles = 0; seq_ok = 1'b1;
    while (!ifc.keys_ready && e < 20) begin
      if (ifc.busy) begin
        busy_cycles++;
        if (int'(ifc.kx_count) != e) seq_ok = 1'b0;
      end
      ifc.key_in  = {$urandom, $urandom, $urandom, $urandom};
      ifc.rd_addr = 4'($urandom_range(0, 15));
      ifc.start   = (mode == 1) && (e == 2 || e == 8 || e == 9);
      if (mode == 2 && e == 4) begin
        ifc.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_int("rst_busy", int'(ifc.busy), 0);
        check_int("rst_ready", int'(ifc.keys_ready), 0);
        check_int("rst_kx_count", int'(ifc.kx_count), 0);
        check_vec("rst_kx_key", ifc.kx_key, '0);
        check_vec("rst_rd_data", ifc.rd_data, '0);
        @(negedge clk);
        ifc.rd_addr = 4'd1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_vec("rst_slot1", ifc.rd_data, '0);
        read_slot(4'd10, d);
        check_vec("rst_slot10", d, '0);
        return;
      end
      @(negedge clk);
      e++;
    end
    ifc.start = 1'b0;
    check_int("ready_latency", e, 10);
    check_int("busy_cycles", busy_cycles, 10);
    check_int("kx_count_seq", int'(seq_ok), 1);
  endtask

  task automatic read_all(input logic [127:0] k);
    logic [127:0] d;
    for (int a = 0; a <= 10; a++) begin
      read_slot(4'(a), d);
      check_vec($sformatf("slot%0d", a), d, round_key(k, a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, k;
    int pulses, run, maxrun, guard;

    ifc.start   = 1'b0;
    ifc.key_in  = '0;
    ifc.rd_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_int("reset_busy", int'(ifc.busy), 0);
    check_int("reset_ready", int'(ifc.keys_ready), 0);
    check_int("reset_kx_count", int'(ifc.kx_count), 0);
    check_vec("reset_kx_key", ifc.kx_key, '0);
    check_vec("reset_rd_data", ifc.rd_data, '0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Pin the reference key schedule to the published vectors.
    check_vec("model_fips_rk1", round_key(FIPS_KEY, 1), FIPS_RK1);
    check_vec("model_fips_rk10", round_key(FIPS_KEY, 10), FIPS_RK10);
    check_vec("model_zero_rk1", round_key('0, 1), ZERO_RK1);
    check_vec("model_zero_rk10", round_key('0, 10), ZERO_RK10);

    // FIPS-197 A.1 key
    expand(FIPS_KEY, 0);
    read_slot(4'd1, d);  check_vec("fips_slot1", d, FIPS_RK1);
    read_slot(4'd10, d); check_vec("fips_slot10", d, FIPS_RK10);
    read_slot(4'd0, d);  check_vec("fips_slot0", d, FIPS_KEY);

    // All-zero key (rekey from DONE)
    expand('0, 0);
    read_slot(4'd1, d);  check_vec("zero_slot1", d, ZERO_RK1);
    read_slot(4'd10, d); check_vec("zero_slot10", d, ZERO_RK10);

    // Stray start pulses and a toggling key_in during expansion
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, 1);
    read_all(k);

    // Reset in the middle of an expansion, then a fresh start
    expand({$urandom, $urandom, $urandom, $urandom}, 2);
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, 0);
    read_all(k);

    // Out-of-range read in DONE, then rekey from DONE
    read_slot(4'd12, d);
    check_vec("rd_addr12", d, '0);
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, 0);
    read_all(k);

    // start held high from DONE: back-to-back expansions, one-cycle ready pulses
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.key_in = {$urandom, $urandom, $urandom, $urandom};
    pulses = 0; run = 0; maxrun = 0;
    repeat (34) begin
      @(negedge clk);
      ifc.rd_addr = 4'($urandom_range(0, 15));
      if (ifc.keys_ready) begin
        pulses++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    ifc.start = 1'b0;
    check_int("b2b_pulses", pulses, 3);
    check_int("b2b_pulse_width", maxrun, 1);
    guard = 0;
    while (!ifc.keys_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_int("b2b_finish", int'(ifc.keys_ready), 1);

    // Randomized keys with random reads
    repeat (6) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k, int'($urandom_range(0, 1)));
      repeat (5) begin
        read_slot(4'($urandom_range(0, 15)), d);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
# aes_key_schedule_ctrl

Sequencer and round-key store that sits directly downstream of the key expansion stage (`Key_exp`). On `start` it latches a 128-bit cipher key and steps the expander through `count` 0..9, one step per clock. It captures each produced round key into an 11-entry store. It then serves round keys 0..10 to the cipher datapath through a registered read port.

## Interface
Parameters:
- `NR`, 10: number of AES-128 rounds; the store holds `NR+1` entries. Only 10 is supported.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a new expansion; sampled only when `busy`=0
- `key_in`  in  128  cipher key, sampled on the accepted `start` edge
- `kx_key`  out  128  key to the expander; the latched key register
- `kx_count`  out  4  round index to the expander
- `kx_out_key`  in  128  round key `kx_count+1` from the expander (combinational)
- `busy`  out  1  expansion in progress
- `keys_ready`  out  1  all 11 round keys valid in the store
- `rd_addr`  in  4  round-key index 0..10
- `rd_data`  out  128  registered read data

## Operation
- FSM states:
  - IDLE: after reset, no valid keys.
  - EXPAND: stepping the expander.
  - DONE: keys valid.
- IDLE or DONE with `start`=1:
  - `key_reg` <= `key_in`.
  - `slot[0]` <= `key_in`.
  - `kx_count` <= 0, `busy` <= 1, `keys_ready` <= 0.
  - Go to EXPAND.
- EXPAND, each cycle with `kx_count`=c:
  - `slot[c+1]` <= `kx_out_key`.
  - If c<9: `kx_count` <= c+1.
  - If c=9: `kx_count` <= 0, `busy` <= 0, `keys_ready` <= 1, go to DONE.
- `kx_count` holds each value for exactly one cycle. The expander's internal register chains round c into round c+1, so no step may be skipped or repeated.
- `kx_key` = `key_reg` at all times. `key_reg` changes only on an accepted `start`, so `key_in` may change freely during expansion.
- `kx_count` is 0 outside EXPAND.
- `start` while `busy`=1 is ignored; there is no queueing.
- Rekey from DONE is allowed. `keys_ready` drops on the accept edge, and the store is overwritten slot by slot.
- Read port: `rd_data` <= `slot[rd_addr]` every cycle for `rd_addr` 0..10. For `rd_addr` 11..15, `rd_data` <= 0.
- Reads are legal in any state. Data is only meaningful while `keys_ready`=1.
- Counter width is 4 bits. `kx_count` never exceeds 9.

## Timing
- Reset values: `busy`=0, `keys_ready`=0, `kx_count`=0, `kx_key`=0 (`key_reg`=0), `rd_data`=0, all slots 0, state IDLE.
- Accepted `start` at edge T0. EXPAND occupies cycles T1..T10, with `kx_count`=0..9.
- `keys_ready`=1 and `busy`=0 from edge T10 onward. Latency from `start` sample to `keys_ready` is 10 edges.
- `slot[0]` is valid from T0. `slot[c+1]` is written at the edge ending the cycle with `kx_count`=c.
- Read latency is 1 cycle: `rd_addr` presented in cycle N appears on `rd_data` in cycle N+1.
- Read-during-write to the same slot returns the old contents.
- `start` asserted on the same edge that enters DONE (EXPAND, c=9) is ignored, because `busy` is still 1 in that cycle.
- `rst_n` low at any time, including mid-EXPAND: asynchronously forces all reset values. Expansion restarts only on a fresh `start` after `rst_n` rises.
- `start` high continuously from DONE:
  - The request is re-accepted immediately.
  - Expansion repeats back to back.
  - `keys_ready` pulses high for one cycle per expansion.

## Test plan
- Apply the FIPS-197 A.1 key `2b7e151628aed2a6abf7158809cf4f3c`, then read slots 0..10. Required:
  - slot 1 = `a0fafe1788542cb123a339392a6c7605`.
  - slot 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `keys_ready` rises exactly 10 edges after `start`.
- Apply the all-zero key. Required:
  - slot 1 = `62636363626363636263636362636363`.
  - slot 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Check `kx_count` sequencing: probe it during EXPAND. Required sequence is 0,1,…,9, one value per cycle, with `busy` high for exactly 10 cycles.
- Pulse `start` with a different `key_in` at T3 and T9 of an expansion, and toggle `key_in` throughout. Required: both requests are ignored, and the result matches the originally latched key.
- Drop `rst_n` at T5. Required:
  - All outputs return to reset values immediately.
  - Reading slot 1 returns 0.
  - A new `start` completes correctly.
- Read with `rd_addr`=12 in DONE. Required: `rd_data`=0 the next cycle. Then rekey from DONE: `keys_ready` goes 0 on the accept edge and returns 1 ten edges later with the new key set.
